// File: rtl/z2_bus_master.sv
// z2_bus_master: 68000 / Zorro II bus initiator.
// Arbitrates for the bus with BR_n/BG_n/BGACK_n, runs single-word
// AS_n/UDS_n/LDS_n/RW cycles for an on-card engine and chains back-to-back
// requests under one tenure up to MAX_BURST. All bus outputs are logical
// levels; the top level tristates the pins whenever BUS_OWNED is 0.
//
// Request handshake (req/ack): the requester raises req with we/addr/be/wdata
// stable and holds them until it sees ack high for one cycle. req is ignored
// in the cycle ack is high, so the requester may drop req, or present the
// next request, immediately after seeing ack. err is only meaningful with ack.
module z2_bus_master #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_BURST      = 4,
    parameter int SETUP_CYCLES   = 1
) (
    input  logic        MEMCLK,
    input  logic        RESET,
    input  logic        req,
    input  logic        we,
    input  logic [22:0] addr,
    input  logic [1:0]  be,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic        BR_n,
    input  logic        BG_n,
    input  logic        BGACK_IN_n,
    output logic        BGACK_n,
    output logic        BUS_OWNED,
    output logic [22:0] ADDR_OUT,
    output logic        AS_n_OUT,
    output logic        UDS_n_OUT,
    output logic        LDS_n_OUT,
    output logic        RW_OUT,
    output logic        DATA_OE,
    output logic [15:0] DBUS_OUT,
    input  logic [15:0] DBUS_IN,
    input  logic        AS_n_IN,
    input  logic        DTACK_n,
    input  logic        BERR_n,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARB     = 3'd1;
    localparam logic [2:0] ST_SETUP   = 3'd2;
    localparam logic [2:0] ST_STROBE  = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_LATCH   = 3'd5;
    localparam logic [2:0] ST_TERM    = 3'd6;
    localparam logic [2:0] ST_RECOVER = 3'd7;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    BURST_MAX  = 4'(MAX_BURST);
    localparam logic [1:0]    SETUP_LAST = 2'(SETUP_CYCLES - 1);

    logic [2:0]    state;
    logic [1:0]    setup_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    burst_cnt;
    logic          cur_we;
    logic [1:0]    cur_be;

    logic [4:0]    sync_meta;
    logic [4:0]    sync_out;
    logic          bg_n_s;
    logic          bgack_in_n_s;
    logic          as_n_in_s;
    logic          dtack_n_s;
    logic          berr_n_s;

    // Two-flop synchronizers for the asynchronous bus inputs, negated out of reset.
    always_ff @(posedge MEMCLK) begin
        if (RESET) begin
            sync_meta <= 5'b11111;
            sync_out  <= 5'b11111;
        end else begin
            sync_meta <= {BG_n, BGACK_IN_n, AS_n_IN, DTACK_n, BERR_n};
            sync_out  <= sync_meta;
        end
    end

    assign bg_n_s       = sync_out[4];
    assign bgack_in_n_s = sync_out[3];
    assign as_n_in_s    = sync_out[2];
    assign dtack_n_s    = sync_out[1];
    assign berr_n_s     = sync_out[0];
    assign state_dbg    = state;

    // Bus-cycle sequencer: arbitration, strobes, termination and tenure chaining.
    always_ff @(posedge MEMCLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            setup_cnt <= 2'd0;
            to_cnt    <= '0;
            burst_cnt <= 4'd0;
            cur_we    <= 1'b0;
            cur_be    <= 2'b00;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= 16'h0000;
            BR_n      <= 1'b1;
            BGACK_n   <= 1'b1;
            BUS_OWNED <= 1'b0;
            ADDR_OUT  <= 23'h0;
            AS_n_OUT  <= 1'b1;
            UDS_n_OUT <= 1'b1;
            LDS_n_OUT <= 1'b1;
            RW_OUT    <= 1'b1;
            DATA_OE   <= 1'b0;
            DBUS_OUT  <= 16'h0000;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req && !ack) begin
                        if (be == 2'b00) begin
                            // Nothing to strobe: refuse without touching the bus.
                            ack <= 1'b1;
                            err <= 1'b1;
                        end else begin
                            BR_n  <= 1'b0;
                            state <= ST_ARB;
                        end
                    end
                end
                ST_ARB: begin
                    // Grant alone is not enough: the previous master must have
                    // finished its cycle and dropped BGACK.
                    if (!bg_n_s && as_n_in_s && dtack_n_s && bgack_in_n_s) begin
                        BGACK_n   <= 1'b0;
                        BR_n      <= 1'b1;
                        BUS_OWNED <= 1'b1;
                        cur_we    <= we;
                        cur_be    <= be;
                        DBUS_OUT  <= wdata;
                        ADDR_OUT  <= addr;
                        RW_OUT    <= ~we;
                        DATA_OE   <= we;
                        setup_cnt <= 2'd0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (setup_cnt == SETUP_LAST) begin
                        AS_n_OUT <= 1'b0;
                        if (!cur_we) begin
                            UDS_n_OUT <= ~cur_be[1];
                            LDS_n_OUT <= ~cur_be[0];
                        end
                        state <= ST_STROBE;
                    end else begin
                        setup_cnt <= setup_cnt + 2'd1;
                    end
                end
                ST_STROBE: begin
                    // Write data strobes trail AS_n by one cycle so D[15:0] is settled.
                    if (cur_we) begin
                        UDS_n_OUT <= ~cur_be[1];
                        LDS_n_OUT <= ~cur_be[0];
                    end
                    to_cnt <= '0;
                    state  <= ST_STROBE + 3'd1;
                end
                ST_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (!berr_n_s || (dtack_n_s && to_cnt == TO_LAST)) begin
                        // BERR wins over a coincident DTACK; timeout ends the same way.
                        AS_n_OUT  <= 1'b1;
                        UDS_n_OUT <= 1'b1;
                        LDS_n_OUT <= 1'b1;
                        ack       <= 1'b1;
                        err       <= 1'b1;
                        burst_cnt <= burst_cnt + 4'd1;
                        state     <= ST_TERM;
                    end else if (!dtack_n_s) begin
                        state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (!cur_we) begin
                        rdata <= DBUS_IN;
                    end
                    AS_n_OUT  <= 1'b1;
                    UDS_n_OUT <= 1'b1;
                    LDS_n_OUT <= 1'b1;
                    ack       <= 1'b1;
                    burst_cnt <= burst_cnt + 4'd1;
                    state     <= ST_TERM;
                end
                ST_TERM: begin
                    // Address, RW and data were held through the strobe negation.
                    DATA_OE <= 1'b0;
                    state   <= ST_RECOVER;
                end
                default: begin
                    // RECOVER: let the target release DTACK/BERR before anything new.
                    if (!ack && dtack_n_s && berr_n_s) begin
                        if (req && be != 2'b00 && burst_cnt < BURST_MAX) begin
                            cur_we    <= we;
                            cur_be    <= be;
                            DBUS_OUT  <= wdata;
                            ADDR_OUT  <= addr;
                            RW_OUT    <= ~we;
                            DATA_OE   <= we;
                            setup_cnt <= 2'd0;
                            state     <= ST_SETUP;
                        end else if (req && be == 2'b00) begin
                            ack <= 1'b1;
                            err <= 1'b1;
                        end else begin
                            BGACK_n   <= 1'b1;
                            BUS_OWNED <= 1'b0;
                            RW_OUT    <= 1'b1;
                            burst_cnt <= 4'd0;
                            state     <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
